// File: rtl/sha1_block_feeder.sv
// Reads a message from dpsram port A, byte-swaps each word to big-endian and
// streams fully padded SHA-1 512-bit blocks as 32-bit words over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start; message parameters latched on start
// ADDR   | port_A_addr holds base + 4k for the current memory word
// WAIT   | RD_LAT cycles for read data; word captured on the last one
// OUT    | word_out presented with word_valid until word_ready
// DONE   | one-cycle done pulse, then back to IDLE
module sha1_block_feeder #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        word_idx,
  output logic              block_last,
  output logic              msg_last,
  output logic [31:0]       num_blocks,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_OUT, S_DONE} state_t;

  state_t      state;
  logic [31:0] size_q;
  logic [31:0] n_words;
  logic [31:0] k;
  logic [7:0]  lat_cnt;

  logic [32:0] size_p8;
  logic [31:0] nb_in;
  logic [31:0] n_in;
  logic [31:0] k_nx;
  logic        unused_bits;

  assign port_A_clk     = clk;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'h0;

  // 33-bit sum so message sizes near 2^32 do not wrap
  assign size_p8 = {1'b0, message_size} + 33'd8;
  assign nb_in   = {5'b0, size_p8[32:6]} + 32'd1;
  assign n_in    = {nb_in[27:0], 4'b0};
  assign k_nx    = k + 32'd1;

  assign unused_bits = &{1'b0, message_addr[31:ADDR_W], nb_in[31:28], size_p8[5:0]};

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic needs_mem(input logic [31:0] kk, input logic [31:0] s);
    return {kk, 2'b00} < {2'b00, s};
  endfunction

  // Padded content of global word kk for a message of s bytes in n words
  function automatic logic [31:0] pad_word(input logic [31:0] kk, input logic [31:0] s,
                                           input logic [31:0] n, input logic [31:0] mem);
    logic [33:0] kb;
    logic [33:0] sz;
    logic [31:0] sw;
    logic [31:0] w;
    kb = {kk, 2'b00};
    sz = {2'b00, s};
    sw = swap32(mem);
    w  = 32'h0;
    if (kb + 34'd4 <= sz) begin
      w = sw;
    end else if (kb < sz) begin
      case (s[1:0])
        2'd1:    w = {sw[31:24], 8'h80, 16'h0};
        2'd2:    w = {sw[31:16], 8'h80, 8'h0};
        default: w = {sw[31:8], 8'h80};
      endcase
    end else if (kb == sz) begin
      w = 32'h8000_0000;
    end else if (kk == n - 32'd2) begin
      w = {29'b0, s[31:29]};
    end else if (kk == n - 32'd1) begin
      w = {s[28:0], 3'b000};
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      size_q      <= 32'h0;
      n_words     <= 32'h0;
      k           <= 32'h0;
      lat_cnt     <= 8'h0;
      port_A_addr <= '0;
      word_out    <= 32'h0;
      word_valid  <= 1'b0;
      word_idx    <= 4'h0;
      block_last  <= 1'b0;
      msg_last    <= 1'b0;
      num_blocks  <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            size_q     <= message_size;
            n_words    <= n_in;
            num_blocks <= nb_in;
            k          <= 32'h0;
            busy       <= 1'b1;
            word_idx   <= 4'h0;
            block_last <= 1'b0;
            msg_last   <= 1'b0;
            // An empty message needs no memory read at all
            if (message_size != 32'h0) begin
              port_A_addr <= message_addr[ADDR_W-1:0];
              state       <= S_ADDR;
            end else begin
              word_out   <= 32'h8000_0000;
              word_valid <= 1'b1;
              state      <= S_OUT;
            end
          end
        end
        S_ADDR: begin
          lat_cnt <= 8'(RD_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == 8'h0) begin
            word_out   <= pad_word(k, size_q, n_words, port_A_data_out);
            word_valid <= 1'b1;
            word_idx   <= k[3:0];
            block_last <= &k[3:0];
            msg_last   <= (k == n_words - 32'd1);
            state      <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt - 8'h1;
          end
        end
        S_OUT: begin
          if (word_ready) begin
            if (msg_last) begin
              word_valid <= 1'b0;
              block_last <= 1'b0;
              msg_last   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              k <= k_nx;
              if (needs_mem(k_nx, size_q)) begin
                word_valid  <= 1'b0;
                port_A_addr <= port_A_addr + ADDR_W'(4);
                state       <= S_ADDR;
              end else begin
                word_out   <= pad_word(k_nx, size_q, n_words, 32'h0);
                word_idx   <= k_nx[3:0];
                block_last <= &k_nx[3:0];
                msg_last   <= (k_nx == n_words - 32'd1);
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_feeder.sv
// Directed bench for sha1_block_feeder: byte-level padding model, hand-checked
// vectors, backpressure, mid-message reset and ignored start.
module tb_sha1_block_feeder;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] message_addr = 32'h0;
  logic [31:0] message_size = 32'h0;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  word_idx;
  logic        block_last;
  logic        msg_last;
  logic [31:0] num_blocks;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:1023];
  logic [31:0] mem_q;
  logic [31:0] got [0:63];
  logic        addr_moved;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= mem[port_A_addr[11:2]];
  assign port_A_data_out = mem_q;

  sha1_block_feeder #(.ADDR_W(16), .RD_LAT(1)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .message_addr(message_addr), .message_size(message_size),
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_idx(word_idx), .block_last(block_last), .msg_last(msg_last),
    .num_blocks(num_blocks), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Byte-oriented reference: message bytes, 0x80, zeros, then 64-bit bit length
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [31:0] size,
                                           input logic [31:0] k, input logic [31:0] n);
    logic [63:0] bits;
    logic [63:0] off;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] mw;
    bits = {32'b0, size} << 3;
    if (k == n - 2) return bits[63:32];
    if (k == n - 1) return bits[31:0];
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      off = 64'(k) * 4 + 64'(j);
      a   = addr + off[31:0];
      w   = w << 8;
      if (off < 64'(size)) begin
        mw = mem[a[11:2]] >> {a[1:0], 3'b000};
        w[7:0] = mw[7:0];
      end else if (off == 64'(size)) begin
        w[7:0] = 8'h80;
      end
    end
    return w;
  endfunction

  task automatic run_msg(input logic [31:0] addr, input logic [31:0] size,
                         input bit bp, input bit poke);
    int          n;
    int          k;
    int          cyc;
    int          budget;
    bit          held;
    logic [31:0] held_word;
    logic [31:0] nb;
    bit          rdy;
    nb     = (size + 32'd8) / 32'd64 + 32'd1;
    n      = int'(nb) * 16;
    budget = n * 10 + 100;
    @(negedge clk);
    message_addr = addr;
    message_size = size;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", {31'b0, busy}, 32'd1);
    chk("num_blocks", num_blocks, nb);
    k = 0;
    cyc = 0;
    held = 1'b0;
    held_word = 32'h0;
    while (k < n && cyc < budget) begin
      if (poke && cyc == 3) begin
        start = 1'b1;
        message_addr = 32'h0000_0300;
        message_size = 32'd7;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (port_A_addr != 16'h0) addr_moved = 1'b1;
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      word_ready = rdy;
      if (held) begin
        chk("held_valid", {31'b0, word_valid}, 32'd1);
        chk("held_word", word_out, held_word);
      end
      held = 1'b0;
      if (word_valid) begin
        if (rdy) begin
          if (k < 64) got[k] = word_out;
          chk($sformatf("word_k%0d", k), word_out, exp_word(addr, size, 32'(k), 32'(n)));
          chk($sformatf("idx_k%0d", k), {28'b0, word_idx}, 32'(k % 16));
          chk($sformatf("blast_k%0d", k), {31'b0, block_last}, (k % 16 == 15) ? 32'd1 : 32'd0);
          chk($sformatf("mlast_k%0d", k), {31'b0, msg_last}, (k == n - 1) ? 32'd1 : 32'd0);
          k++;
        end else begin
          held = 1'b1;
          held_word = word_out;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("words_accepted", 32'(k), 32'(n));
    word_ready = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk("valid_at_done", {31'b0, word_valid}, 32'd0);
    chk("nblk_at_done", num_blocks, nb);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    mem[32'h0100 >> 2] = 32'h0063_6261;
    addr_moved = 1'b0;

    #1;
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_blast", {31'b0, block_last}, 32'd0);
    chk("rst_mlast", {31'b0, msg_last}, 32'd0);
    chk("rst_word", word_out, 32'h0);
    chk("rst_idx", {28'b0, word_idx}, 32'h0);
    chk("rst_nblk", num_blocks, 32'h0);
    chk("rst_addr", {16'b0, port_A_addr}, 32'h0);
    chk("tie_we", {31'b0, port_A_we}, 32'd0);
    chk("tie_din", port_A_data_in, 32'h0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // Empty message: pad-only block, memory never addressed
    run_msg(32'h0000_0400, 32'd0, 1'b0, 1'b0);
    chk("s0_word0", got[0], 32'h8000_0000);
    chk("s0_word15", got[15], 32'h0);
    chk("s0_addr_still", {31'b0, addr_moved}, 32'd0);

    run_msg(32'h0000_0100, 32'd3, 1'b0, 1'b0);
    chk("abc_word0", got[0], 32'h6162_6380);
    chk("abc_word1", got[1], 32'h0);
    chk("abc_word15", got[15], 32'h0000_0018);

    run_msg(32'h0000_0600, 32'd56, 1'b0, 1'b0);
    chk("s56_word14", got[14], 32'h8000_0000);
    chk("s56_word15", got[15], 32'h0);
    chk("s56_word30", got[30], 32'h0);
    chk("s56_word31", got[31], 32'h0000_01C0);

    run_msg(32'h0000_0400, 32'd64, 1'b1, 1'b0);
    chk("s64_word16", got[16], 32'h8000_0000);
    chk("s64_word31", got[31], 32'h0000_0200);

    // Reset in the middle of the first block
    @(negedge clk);
    message_addr = 32'h0000_0200;
    message_size = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    word_ready = 1'b1;
    repeat (20) @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("abort_valid", {31'b0, word_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("abort_valid_next", {31'b0, word_valid}, 32'd0);
    chk("abort_nblk", num_blocks, 32'h0);
    word_ready = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    run_msg(32'h0000_0200, 32'd100, 1'b0, 1'b0);
    chk("s100_word25", got[25], 32'h8000_0000);
    chk("s100_word31", got[31], 32'h0000_0320);

    // start pulsed while busy must not disturb the running message
    run_msg(32'h0000_0800, 32'd21, 1'b0, 1'b1);
    chk("poke_word5", got[5], {exp_word(32'h0000_0800, 32'd21, 32'd5, 32'd16)});
    chk("poke_word15", got[15], 32'h0000_00A8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
